inv_add_mix_col: RTL



---
 rtl/aes_pkg.sv | 50 +++++
 rtl/inv_mix_single_col.sv | 19 +
 rtl/inv_add_mix_col.sv | 130 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES decrypt definitions: widths, FSM encoding and GF(2^8) helpers
// used by the InvMixColumns column transform.
package aes_pkg;

    localparam int STATE_W  = 128;
    localparam int WORD_W   = 32;
    localparam int BYTE_W   = 8;
    localparam int NUM_COLS = 4;
    localparam int COL_W    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [BYTE_W-1:0] gmul9(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [BYTE_W-1:0] gmul11(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] x2, x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [BYTE_W-1:0] gmul13(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] x4, x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [BYTE_W-1:0] gmul14(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_single_col.sv
// Combinational InvMixColumns transform of one 32-bit column
// (byte a0 in the top bits).
module inv_mix_single_col
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] col_in,
    output logic [WORD_W-1:0] col_out
);

    logic [BYTE_W-1:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_in;

    assign col_out[31:24] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
    assign col_out[23:16] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
    assign col_out[15:8]  = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
    assign col_out[7:0]   = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);

endmodule

// File: rtl/inv_add_mix_col.sv
// Decrypt-round stage: AddRoundKey then InvMixColumns, one column per cycle.
// Define INV_MIX_PARALLEL_EN to process all four columns in a single cycle.
module inv_add_mix_col #(
    parameter int NUM_COLS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [aes_pkg::STATE_W-1:0] state_in,
    input  logic [aes_pkg::STATE_W-1:0] round_key,
    input  logic                       last_round,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [aes_pkg::STATE_W-1:0] state_out
);
    import aes_pkg::*;

    if (NUM_COLS != aes_pkg::NUM_COLS) begin : g_bad_num_cols
        $error("inv_add_mix_col supports NUM_COLS == 4 only");
    end

    fsm_t               fsm, fsm_next;
    logic [COL_W-1:0]   col;
    logic [STATE_W-1:0] state_reg, key_reg, out_reg;
    logic               last_reg;
    logic [STATE_W-1:0] busy_result;
    logic               busy_last;

`ifdef INV_MIX_PARALLEL_EN
    logic [STATE_W-1:0] sum_all, mix_all;

    assign sum_all = state_reg ^ key_reg;

    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
        inv_mix_single_col u_mix (
            .col_in (sum_all[STATE_W-1-WORD_W*gi -: WORD_W]),
            .col_out(mix_all[STATE_W-1-WORD_W*gi -: WORD_W])
        );
    end

    assign busy_result = last_reg ? sum_all : mix_all;
    assign busy_last   = 1'b1;
`else
    logic [WORD_W-1:0] sel_state, sel_key, sum_col, mix_col, new_col;

    always_comb begin
        sel_state = '0;
        sel_key   = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (int'(col) == c) begin
                sel_state = state_reg[STATE_W-1-WORD_W*c -: WORD_W];
                sel_key   = key_reg[STATE_W-1-WORD_W*c -: WORD_W];
            end
        end
    end

    assign sum_col = sel_state ^ sel_key;

    inv_mix_single_col u_mix (
        .col_in (sum_col),
        .col_out(mix_col)
    );

    assign new_col = last_reg ? sum_col : mix_col;

    // The finished column is written back in place, so the final cycle's
    // merged state is the complete result.
    always_comb begin
        busy_result = state_reg;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (int'(col) == c) begin
                busy_result[STATE_W-1-WORD_W*c -: WORD_W] = new_col;
            end
        end
    end

    assign busy_last = (col == COL_W'(NUM_COLS - 1));
`endif

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (in_valid) fsm_next = BUSY;
            BUSY:    if (busy_last) fsm_next = DONE;
            DONE:    if (out_ready) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    // out_reg is separate from the working state so the result stays put
    // after the handshake and while the next block is being processed.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            col       <= '0;
            state_reg <= '0;
            key_reg   <= '0;
            last_reg  <= 1'b0;
            out_reg   <= '0;
        end else begin
            fsm <= fsm_next;
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= state_in;
                        key_reg   <= round_key;
                        last_reg  <= last_round;
                        col       <= '0;
                    end
                end
                BUSY: begin
                    state_reg <= busy_result;
                    if (busy_last) begin
                        col     <= '0;
                        out_reg <= busy_result;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign state_out = out_reg;

endmodule
